// File: rtl/ram_rw_bridge.sv
// ram_rw_bridge: arbitrates an instruction-fetch port and a load/store port
// onto one word-indexed RAM port, building byte masks / shifted store data and
// extracting + extending load data.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   if_*                fetch request/response (32-bit instruction, err)
//   ls_*                load/store request/response (size[1:0]=log2 bytes,
//                       size[2]=zero-extend load)
//   ram_*               RAM port: enable, word index, read word (comb from
//                       index), write enable, shifted write word, bit mask
module ram_rw_bridge #(
  parameter int unsigned   AW       = 64,
  parameter int unsigned   DW       = 64,
  parameter logic [AW-1:0] PC_START = 64'h0000_0000_8000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ready_o,
  output logic [31:0]   if_rdata_o,
  output logic          if_err_o,
  input  logic          ls_req_i,
  input  logic          ls_wen_i,
  input  logic [AW-1:0] ls_addr_i,
  input  logic [2:0]    ls_size_i,
  input  logic [DW-1:0] ls_wdata_i,
  output logic          ls_ready_o,
  output logic [DW-1:0] ls_rdata_o,
  output logic          ls_err_o,
  output logic          ram_en_o,
  output logic [AW-1:0] ram_idx_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          ram_wen_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic [DW-1:0] ram_wmask_o
);

  localparam int unsigned IW = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e          state_q, state_d;
  logic            is_ls_q, is_ls_d;
  logic            wen_q, wen_d;
  logic [2:0]      off_q, off_d;
  logic [2:0]      size_q, size_d;
  logic            if_ready_q, if_ready_d;
  logic [IW-1:0]   if_rdata_q, if_rdata_d;
  logic            if_err_q, if_err_d;
  logic            ls_ready_q, ls_ready_d;
  logic [DW-1:0]   ls_rdata_q, ls_rdata_d;
  logic            ls_err_q, ls_err_d;
  logic            ram_en_q, ram_en_d;
  logic [AW-1:0]   ram_idx_q, ram_idx_d;
  logic            ram_wen_q, ram_wen_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DW-1:0]   ram_wmask_q, ram_wmask_d;

  // Request selected in IDLE (ls wins) and its decoded attributes
  logic            sel_ls;
  logic [AW-1:0]   sel_addr;
  logic [2:0]      sel_size;
  logic [2:0]      sel_off;
  logic [3:0]      sel_nbytes;
  logic            sel_err;
  logic [7:0]      sel_bmask;
  logic [DW-1:0]   rd_shift;
  logic [DW-1:0]   load_ext;

  always_comb begin
    sel_ls     = ls_req_i;
    sel_addr   = sel_ls ? ls_addr_i : if_addr_i;
    sel_size   = sel_ls ? ls_size_i : 3'b010;
    sel_off    = sel_addr[2:0];
    sel_nbytes = 4'(1) << sel_size[1:0];
    sel_err    = (sel_addr < PC_START) |
                 (sel_ls ? (({1'b0, sel_off} + sel_nbytes) > 4'd8)
                         : (sel_addr[1:0] != 2'b00));
    // Only meaningful for non-crossing accesses; crossing ones never reach RAM
    sel_bmask  = 8'(((9'(1) << sel_nbytes) - 9'(1)) << sel_off);
  end

  // Load data: align the captured word, then truncate and extend
  always_comb begin
    rd_shift = ram_rdata_i >> {off_q, 3'b000};
    unique case (size_q[1:0])
      2'd0:    load_ext = size_q[2] ? DW'(rd_shift[7:0])
                                    : {{(DW-8){rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    load_ext = size_q[2] ? DW'(rd_shift[15:0])
                                    : {{(DW-16){rd_shift[15]}}, rd_shift[15:0]};
      2'd2:    load_ext = size_q[2] ? DW'(rd_shift[31:0])
                                    : {{(DW-32){rd_shift[31]}}, rd_shift[31:0]};
      default: load_ext = rd_shift;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    is_ls_d     = is_ls_q;
    wen_d       = wen_q;
    off_d       = off_q;
    size_d      = size_q;
    if_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    ls_ready_d  = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    ls_err_d    = ls_err_q;
    ram_en_d    = 1'b0;
    ram_idx_d   = '0;
    ram_wen_d   = 1'b0;
    ram_wdata_d = '0;
    ram_wmask_d = '0;

    unique case (state_q)
      IDLE: begin
        if (ls_req_i || if_req_i) begin
          is_ls_d = sel_ls;
          wen_d   = sel_ls & ls_wen_i;
          off_d   = sel_off;
          size_d  = sel_size;
          if (sel_err) begin
            // Error responses skip the RAM and return zero data
            state_d = RESP;
            if (sel_ls) begin
              ls_ready_d = 1'b1;
              ls_err_d   = 1'b1;
              ls_rdata_d = '0;
            end else begin
              if_ready_d = 1'b1;
              if_err_d   = 1'b1;
              if_rdata_d = '0;
            end
          end else begin
            state_d   = ACCESS;
            ram_en_d  = 1'b1;
            ram_idx_d = (sel_addr - PC_START) >> 3;
            if (sel_ls && ls_wen_i) begin
              ram_wen_d   = 1'b1;
              ram_wdata_d = ls_wdata_i << {sel_off, 3'b000};
              for (int b = 0; b < 8; b++) begin
                ram_wmask_d[8*b +: 8] = {8{sel_bmask[b]}};
              end
            end
          end
        end
      end
      ACCESS: begin
        // Capture the RAM word into the response registers
        state_d = RESP;
        if (is_ls_q) begin
          ls_ready_d = 1'b1;
          ls_err_d   = 1'b0;
          ls_rdata_d = wen_q ? '0 : load_ext;
        end else begin
          if_ready_d = 1'b1;
          if_err_d   = 1'b0;
          if_rdata_d = off_q[2] ? ram_rdata_i[DW-1:IW] : ram_rdata_i[IW-1:0];
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      is_ls_q     <= 1'b0;
      wen_q       <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ls_ready_q  <= 1'b0;
      ls_rdata_q  <= '0;
      ls_err_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_idx_q   <= '0;
      ram_wen_q   <= 1'b0;
      ram_wdata_q <= '0;
      ram_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      is_ls_q     <= is_ls_d;
      wen_q       <= wen_d;
      off_q       <= off_d;
      size_q      <= size_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      ls_ready_q  <= ls_ready_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_err_q    <= ls_err_d;
      ram_en_q    <= ram_en_d;
      ram_idx_q   <= ram_idx_d;
      ram_wen_q   <= ram_wen_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wmask_q <= ram_wmask_d;
    end
  end

  assign if_ready_o  = if_ready_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_err_o    = if_err_q;
  assign ls_ready_o  = ls_ready_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign ls_err_o    = ls_err_q;
  assign ram_en_o    = ram_en_q;
  assign ram_idx_o   = ram_idx_q;
  assign ram_wen_o   = ram_wen_q;
  assign ram_wdata_o = ram_wdata_q;
  assign ram_wmask_o = ram_wmask_q;

endmodule

// File: tb/tb_ram_rw_bridge.sv
// Directed self-checking bench for ram_rw_bridge with a small behavioural RAM.
module tb_ram_rw_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_i = 1'b0;
  logic [63:0] if_addr_i = '0;
  logic        if_ready_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;
  logic        ls_req_i = 1'b0;
  logic        ls_wen_i = 1'b0;
  logic [63:0] ls_addr_i = '0;
  logic [2:0]  ls_size_i = '0;
  logic [63:0] ls_wdata_i = '0;
  logic        ls_ready_o;
  logic [63:0] ls_rdata_o;
  logic        ls_err_o;
  logic        ram_en_o;
  logic [63:0] ram_idx_o;
  logic [63:0] ram_rdata_i;
  logic        ram_wen_o;
  logic [63:0] ram_wdata_o;
  logic [63:0] ram_wmask_o;

  int n_pass  = 0;
  int n_total = 0;
  int en_cnt  = 0;
  int wen_cnt = 0;

  logic [63:0] mem [16] = '{0: 64'h80FF_EE00_CAFE_F00D,
                            2: 64'h1122_3344_5566_7788,
                            3: 64'h0123_4567_89AB_CDEF,
                            default: 64'h0};

  ram_rw_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
    .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_wen_i(ls_wen_i), .ls_addr_i(ls_addr_i),
    .ls_size_i(ls_size_i), .ls_wdata_i(ls_wdata_i), .ls_ready_o(ls_ready_o),
    .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .ram_en_o(ram_en_o), .ram_idx_o(ram_idx_o), .ram_rdata_i(ram_rdata_i),
    .ram_wen_o(ram_wen_o), .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o)
  );

  always #5 clk = ~clk;

  assign ram_rdata_i = mem[ram_idx_o[3:0]];

  // Behavioural RAM write port and access counters
  always @(posedge clk) begin
    if (ram_en_o) en_cnt = en_cnt + 1;
    if (ram_en_o && ram_wen_o) begin
      wen_cnt = wen_cnt + 1;
      mem[ram_idx_o[3:0]] = (mem[ram_idx_o[3:0]] & ~ram_wmask_o) |
                            (ram_wdata_o & ram_wmask_o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ls_txn(input logic wen, input logic [63:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata, input int exp_lat,
                        input logic [63:0] exp_rd, input logic exp_err, input string tag);
    int lat;
    lat = 0;
    ls_wen_i = wen; ls_addr_i = addr; ls_size_i = size; ls_wdata_i = wdata;
    ls_req_i = 1'b1;
    while (ls_ready_o !== 1'b1 && lat < 8) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_rdata"}, ls_rdata_o, exp_rd);
    chk({tag, "_err"}, 64'(ls_err_o), 64'(exp_err));
    ls_req_i = 1'b0;
    step();
  endtask

  task automatic if_txn(input logic [63:0] addr, input int exp_lat,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int lat;
    lat = 0;
    if_addr_i = addr;
    if_req_i = 1'b1;
    while (if_ready_o !== 1'b1 && lat < 8) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_rdata"}, 64'(if_rdata_o), 64'(exp_rd));
    chk({tag, "_err"}, 64'(if_err_o), 64'(exp_err));
    if_req_i = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, wen0, ls_at, if_at;
    logic seen;

    // Reset: everything zero during and after reset
    #2;
    chk("rst_ctrl", 64'({if_ready_o, if_err_o, if_rdata_o, ls_ready_o, ls_err_o,
                         ram_en_o, ram_wen_o}), 64'h0);
    chk("rst_ls_rdata", ls_rdata_o, 64'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ram", ram_idx_o | ram_wdata_o | ram_wmask_o, 64'h0);

    // Doubleword load from word 2, checked cycle by cycle
    ls_wen_i = 1'b0; ls_addr_i = 64'h8000_0010; ls_size_i = 3'd3; ls_req_i = 1'b1;
    step();
    chk("ld_access_en", 64'(ram_en_o), 64'h1);
    chk("ld_access_idx", ram_idx_o, 64'h2);
    chk("ld_access_ready", 64'(ls_ready_o), 64'h0);
    step();
    chk("ld_resp_ready", 64'(ls_ready_o), 64'h1);
    chk("ld_resp_rdata", ls_rdata_o, 64'h1122_3344_5566_7788);
    chk("ld_resp_err", 64'(ls_err_o), 64'h0);
    chk("ld_resp_en", 64'(ram_en_o), 64'h0);
    ls_req_i = 1'b0;
    step();
    chk("ld_ready_pulse", 64'(ls_ready_o), 64'h0);
    chk("ld_rdata_hold", ls_rdata_o, 64'h1122_3344_5566_7788);

    // Byte store at offset 5
    wen0 = wen_cnt;
    ls_wen_i = 1'b1; ls_addr_i = 64'h8000_0005; ls_size_i = 3'd0;
    ls_wdata_i = 64'hAB; ls_req_i = 1'b1;
    step();
    chk("st_wen", 64'(ram_wen_o), 64'h1);
    chk("st_idx", ram_idx_o, 64'h0);
    chk("st_wmask", ram_wmask_o, 64'h0000_FF00_0000_0000);
    chk("st_wdata", ram_wdata_o, 64'h0000_AB00_0000_0000);
    step();
    chk("st_wen_drop", 64'(ram_wen_o), 64'h0);
    chk("st_wmask_drop", ram_wmask_o, 64'h0);
    chk("st_ready", 64'(ls_ready_o), 64'h1);
    chk("st_rdata", ls_rdata_o, 64'h0);
    ls_req_i = 1'b0;
    step();
    chk("st_wen_count", 64'(wen_cnt - wen0), 64'h1);

    // Loads with sign / zero extension from the modified word 0
    ls_txn(1'b0, 64'h8000_0000, 3'd3, '0, 2, 64'h80FF_AB00_CAFE_F00D, 1'b0, "ld_d_after_st");
    ls_txn(1'b0, 64'h8000_0007, 3'd0, '0, 2, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, "ld_b_sext");
    ls_txn(1'b0, 64'h8000_0007, 3'd4, '0, 2, 64'h0000_0000_0000_0080, 1'b0, "ld_b_zext");
    ls_txn(1'b0, 64'h8000_0002, 3'd1, '0, 2, 64'hFFFF_FFFF_FFFF_CAFE, 1'b0, "ld_h_sext");
    ls_txn(1'b0, 64'h8000_0004, 3'd2, '0, 2, 64'hFFFF_FFFF_80FF_AB00, 1'b0, "ld_w_sext");
    ls_txn(1'b0, 64'h8000_0004, 3'd6, '0, 2, 64'h0000_0000_80FF_AB00, 1'b0, "ld_w_zext");
    if_txn(64'h8000_0010, 2, 32'h5566_7788, 1'b0, "fetch_lo");

    // Simultaneous requests: ls first, fetch three cycles later
    ls_wen_i = 1'b0; ls_addr_i = 64'h8000_0000; ls_size_i = 3'd3; ls_req_i = 1'b1;
    if_addr_i = 64'h8000_0004; if_req_i = 1'b1;
    ls_at = -1; if_at = -1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (ls_ready_o === 1'b1) begin
        ls_at = c;
        chk("both_ls_rdata", ls_rdata_o, 64'h80FF_AB00_CAFE_F00D);
        ls_req_i = 1'b0;
      end
      if (if_ready_o === 1'b1) begin
        if_at = c;
        chk("both_if_rdata", 64'(if_rdata_o), 64'h80FF_AB00);
        if_req_i = 1'b0;
      end
    end
    chk("both_ls_latency", 64'(ls_at), 64'd2);
    chk("both_if_latency", 64'(if_at), 64'd5);
    if_req_i = 1'b0; ls_req_i = 1'b0;
    step();

    // Error requests: one-cycle latency, zero data, no RAM access
    en0 = en_cnt;
    ls_txn(1'b0, 64'h8000_0006, 3'd2, '0, 1, 64'h0, 1'b1, "ls_err_cross");
    ls_txn(1'b0, 64'h7FFF_FFF8, 3'd3, '0, 1, 64'h0, 1'b1, "ls_err_low");
    if_txn(64'h7FFF_FFFC, 1, 32'h0, 1'b1, "if_err_low");
    if_txn(64'h8000_0002, 1, 32'h0, 1'b1, "if_err_align");
    chk("err_no_ram_en", 64'(en_cnt - en0), 64'h0);
    // Boundary: ends exactly at the word edge, so no error
    ls_txn(1'b0, 64'h8000_0016, 3'd1, '0, 2, 64'h0000_0000_0000_1122, 1'b0, "ld_h_edge");

    // Reset during the ACCESS cycle of a store
    wen0 = wen_cnt;
    ls_wen_i = 1'b1; ls_addr_i = 64'h8000_0018; ls_size_i = 3'd3;
    ls_wdata_i = 64'hFFFF_0000_FFFF_0000; ls_req_i = 1'b1;
    step();
    chk("rst_mid_wen_before", 64'(ram_wen_o), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wen_drop", 64'(ram_wen_o), 64'h0);
    chk("rst_mid_en_drop", 64'(ram_en_o), 64'h0);
    ls_req_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      seen = seen | ls_ready_o | if_ready_o;
      if (c == 1) rst_n = 1'b1;
    end
    chk("rst_mid_no_ready", 64'(seen), 64'h0);
    chk("rst_mid_no_commit", 64'(wen_cnt - wen0), 64'h0);
    chk("rst_mid_outs_zero", 64'({if_ready_o, if_err_o, if_rdata_o, ls_ready_o, ls_err_o,
                                  ram_en_o, ram_wen_o}) | ls_rdata_o | ram_idx_o |
                             ram_wdata_o | ram_wmask_o, 64'h0);
    ls_txn(1'b0, 64'h8000_0018, 3'd3, '0, 2, 64'h0123_4567_89AB_CDEF, 1'b0, "ld_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
